// File: rtl/mod_step_counter.sv
// mod_step_counter: WIDTH-bit modulo-MODULUS up/down counter with parallel
// load, push-button stepping (edge or level), wrap/saturate mode,
// terminal-count pulse and sticky overflow flag.
module mod_step_counter #(
   parameter int WIDTH     = 8,
   parameter int MODULUS   = 200,
   parameter bit EDGE_STEP = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_n,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step,
   input  logic             up,
   input  logic             sat,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   // One extra bit keeps q+1 from aliasing when MODULUS equals 2^WIDTH.
   localparam logic [WIDTH:0] MAX_E = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE_E = (WIDTH+1)'(1);

   generate
      if ((WIDTH < 2) || (WIDTH > 16) || (MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_params
         $error("mod_step_counter: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   logic cnt_en;

   generate
      if (EDGE_STEP) begin : g_edge
         logic s1;
         logic s2;
         logic s3;

         // Two-flop synchroniser on the asynchronous button level plus an edge flop.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s1 <= 1'b0;
               s2 <= 1'b0;
               s3 <= 1'b0;
            end else begin
               s1 <= step;
               s2 <= s1;
               s3 <= s2;
            end
         end

         assign cnt_en = s2 & ~s3;
      end else begin : g_level
         assign cnt_en = step;
      end
   endgenerate

   logic [WIDTH:0]   q_e;
   logic [WIDTH:0]   nxt_e;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] load_q;
   logic             over;
   logic             at_max;
   logic             at_min;
   logic             limit;

   assign q_e    = {1'b0, q};
   assign over   = (q_e > MAX_E);
   assign at_max = (q_e == MAX_E);
   assign at_min = (q_e == '0);

   // Next count value and limit detection for the current direction/mode.
   always_comb begin
      nxt_e = q_e;
      limit = 1'b0;
      if (over) begin
         // Unreachable in normal use; snap back into range without flagging.
         nxt_e = up ? '0 : MAX_E;
      end else if (up) begin
         if (at_max) begin
            limit = 1'b1;
            nxt_e = sat ? q_e : '0;
         end else begin
            nxt_e = q_e + ONE_E;
         end
      end else begin
         if (at_min) begin
            limit = 1'b1;
            nxt_e = sat ? q_e : MAX_E;
         end else begin
            nxt_e = q_e - ONE_E;
         end
      end
   end

   // The top bit can only be set by an out-of-range sum; treat that as zero.
   assign q_d    = nxt_e[WIDTH] ? '0 : nxt_e[WIDTH-1:0];
   assign load_q = ({1'b0, load_val} > MAX_E) ? MAX_E[WIDTH-1:0] : load_val;

   // Count register with reset > load > count priority; ovf set beats clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else if (!load_n) begin
         q   <= load_q;
         tc  <= 1'b0;
         ovf <= ovf & ~clr_ovf;
      end else begin
         if (cnt_en) begin
            q <= q_d;
         end
         tc  <= cnt_en & limit;
         ovf <= (cnt_en & limit) | (ovf & ~clr_ovf);
      end
   end

endmodule

// File: tb/tb_mod_step_counter.sv
// Bench for mod_step_counter: an edge-stepped 8-bit/200 instance (A) and a
// level-stepped 4-bit/16 instance (B), each with its own event scoreboard.
module tb_mod_step_counter;

   typedef struct {
      int cyc;
      int q;
      bit tc;
   } ev_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_on = 1'b0;

   ev_t sb_a[$];
   ev_t sb_b[$];

   int mq_a = 0;
   bit movf_a = 1'b0;
   int mq_b = 0;
   bit movf_b = 1'b0;

   logic       rst_n;
   logic       a_load_n, a_step, a_up, a_sat, a_clr;
   logic [7:0] a_load_val;
   logic [7:0] a_q;
   logic       a_tc, a_ovf;
   logic [7:0] a_prev;

   logic       b_load_n, b_step, b_up, b_sat, b_clr;
   logic [3:0] b_load_val;
   logic [3:0] b_q;
   logic       b_tc, b_ovf;
   logic [3:0] b_prev;

   mod_step_counter #(.WIDTH(8), .MODULUS(200), .EDGE_STEP(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .load_n(a_load_n), .load_val(a_load_val),
      .step(a_step), .up(a_up), .sat(a_sat), .clr_ovf(a_clr),
      .q(a_q), .tc(a_tc), .ovf(a_ovf)
   );

   mod_step_counter #(.WIDTH(4), .MODULUS(16), .EDGE_STEP(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .load_n(b_load_n), .load_val(b_load_val),
      .step(b_step), .up(b_up), .sat(b_sat), .clr_ovf(b_clr),
      .q(b_q), .tc(b_tc), .ovf(b_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Scoreboard A: every q change or tc pulse must match the next expected event.
   always @(negedge clk) begin
      if (mon_on && (a_q !== a_prev || a_tc !== 1'b0)) begin
         vectors++;
         if (sb_a.size() == 0) begin
            miscompares++;
            $display("FAIL sb_a_unexpected: got q=%0d tc=%b at cycle %0d, required no event", a_q, a_tc, cyc);
         end else begin
            ev_t e;
            e = sb_a.pop_front();
            if (a_q !== e.q[7:0] || a_tc !== e.tc || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL sb_a_event: got q=%0d tc=%b cycle=%0d, required q=%0d tc=%b cycle=%0d",
                        a_q, a_tc, cyc, e.q, e.tc, e.cyc);
            end
         end
      end
      a_prev = a_q;
   end

   // Scoreboard B.
   always @(negedge clk) begin
      if (mon_on && (b_q !== b_prev || b_tc !== 1'b0)) begin
         vectors++;
         if (sb_b.size() == 0) begin
            miscompares++;
            $display("FAIL sb_b_unexpected: got q=%0d tc=%b at cycle %0d, required no event", b_q, b_tc, cyc);
         end else begin
            ev_t e;
            e = sb_b.pop_front();
            if (b_q !== e.q[3:0] || b_tc !== e.tc || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL sb_b_event: got q=%0d tc=%b cycle=%0d, required q=%0d tc=%b cycle=%0d",
                        b_q, b_tc, cyc, e.q, e.tc, e.cyc);
            end
         end
      end
      b_prev = b_q;
   end

   function automatic void model_step(input int cur, input bit dir_up, input bit sat_mode,
                                      input int m, output int nq, output bit lim);
      if (dir_up) begin
         lim = (cur == m - 1);
         nq  = lim ? (sat_mode ? cur : 0) : cur + 1;
      end else begin
         lim = (cur == 0);
         nq  = lim ? (sat_mode ? 0 : m - 1) : cur - 1;
      end
   endfunction

   task automatic push_a(input int due, input int nq, input bit lim);
      ev_t e;
      e.cyc = due;
      e.q   = nq;
      e.tc  = lim;
      sb_a.push_back(e);
   endtask

   // One button press on A held for 'hold' clocks, then released.
   task automatic press_a(input int hold);
      int nq;
      bit lim;
      @(negedge clk);
      model_step(mq_a, a_up, a_sat, 200, nq, lim);
      push_a(cyc + 3, nq, lim);
      if (lim) movf_a = 1'b1;
      mq_a = nq;
      a_step = 1'b1;
      repeat (hold) @(negedge clk);
      a_step = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic load_a(input int val);
      int exp_q;
      @(negedge clk);
      exp_q = (val < 200) ? val : 199;
      a_load_val = val[7:0];
      a_load_n = 1'b0;
      if (exp_q != mq_a) push_a(cyc + 1, exp_q, 1'b0);
      mq_a = exp_q;
      @(negedge clk);
      a_load_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (a_q !== 8'd0 || a_tc !== 1'b0 || a_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_a: got q=%0d tc=%b ovf=%b, required 0 0 0", a_q, a_tc, a_ovf);
      end
      vectors++;
      if (b_q !== 4'd0 || b_tc !== 1'b0 || b_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_b: got q=%0d tc=%b ovf=%b, required 0 0 0", b_q, b_tc, b_ovf);
      end
      rst_n = 1'b1;
      mon_on = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_count_presses;
      for (int i = 0; i < 3; i++) press_a(10);
      vectors++;
      if (a_q !== 8'd3 || a_ovf !== 1'b0 || sb_a.size() != 0) begin
         miscompares++;
         $display("FAIL count_presses: got q=%0d ovf=%b pending=%0d, required q=3 ovf=0 pending=0",
                  a_q, a_ovf, sb_a.size());
      end
   endtask

   task automatic test_wrap_up;
      a_up = 1'b1;
      a_sat = 1'b0;
      load_a(198);
      press_a(3);
      press_a(3);
      vectors++;
      if (a_q !== 8'd0 || a_ovf !== 1'b1 || sb_a.size() != 0) begin
         miscompares++;
         $display("FAIL wrap_up: got q=%0d ovf=%b pending=%0d, required q=0 ovf=1 pending=0",
                  a_q, a_ovf, sb_a.size());
      end
      @(negedge clk);
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      movf_a = 1'b0;
      vectors++;
      if (a_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_ovf: got ovf=%b, required 0", a_ovf);
      end
   endtask

   task automatic test_sat_down;
      a_up = 1'b0;
      a_sat = 1'b1;
      press_a(2);
      vectors++;
      if (a_q !== 8'd0 || a_ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_down: got q=%0d ovf=%b, required q=0 ovf=1", a_q, a_ovf);
      end
      a_sat = 1'b0;
      press_a(2);
      vectors++;
      if (a_q !== 8'd199 || sb_a.size() != 0) begin
         miscompares++;
         $display("FAIL wrap_down: got q=%0d pending=%0d, required q=199 pending=0", a_q, sb_a.size());
      end
   endtask

   // Limit event and clr_ovf on the same edge: the set must win.
   task automatic test_set_wins;
      int c;
      @(negedge clk);
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      vectors++;
      if (a_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL set_wins_pre: got ovf=%b, required 0", a_ovf);
      end
      a_up = 1'b1;
      @(negedge clk);
      c = cyc;
      push_a(c + 3, 0, 1'b1);
      mq_a = 0;
      a_step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      a_step = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (a_ovf !== 1'b1 || a_q !== 8'd0) begin
         miscompares++;
         $display("FAIL set_wins: got ovf=%b q=%0d, required ovf=1 q=0", a_ovf, a_q);
      end
   endtask

   task automatic test_load_clamp;
      int c;
      load_a(250);
      @(negedge clk);
      vectors++;
      if (a_q !== 8'd199) begin
         miscompares++;
         $display("FAIL load_clamp: got q=%0d, required 199", a_q);
      end
      a_up = 1'b1;
      @(negedge clk);
      c = cyc;
      a_step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      a_load_val = 8'd57;
      a_load_n = 1'b0;
      push_a(c + 3, 57, 1'b0);
      mq_a = 57;
      @(negedge clk);
      a_load_n = 1'b1;
      repeat (4) @(negedge clk);
      a_step = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (a_q !== 8'd57 || sb_a.size() != 0 || a_ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL load_drops_count: got q=%0d ovf=%b pending=%0d, required q=57 ovf=1 pending=0",
                  a_q, a_ovf, sb_a.size());
      end
   endtask

   task automatic test_reset_mid;
      int c;
      load_a(100);
      @(negedge clk);
      c = cyc;
      a_step = 1'b1;
      @(negedge clk);
      a_step = 1'b0;
      rst_n = 1'b0;
      push_a(c + 2, 0, 1'b0);
      mq_a = 0;
      movf_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if (a_q !== 8'd0 || a_ovf !== 1'b0 || a_tc !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got q=%0d ovf=%b tc=%b, required 0 0 0", a_q, a_ovf, a_tc);
      end
      repeat (6) @(negedge clk);
      vectors++;
      if (a_q !== 8'd0 || sb_a.size() != 0) begin
         miscompares++;
         $display("FAIL reset_drops_step: got q=%0d pending=%0d, required q=0 pending=0", a_q, sb_a.size());
      end
   endtask

   task automatic test_level_mode;
      int c;
      int nq;
      bit lim;
      b_up = 1'b1;
      b_sat = 1'b0;
      @(negedge clk);
      c = cyc;
      for (int i = 0; i < 20; i++) begin
         ev_t e;
         model_step(mq_b, 1'b1, 1'b0, 16, nq, lim);
         e.cyc = c + 1 + i;
         e.q   = nq;
         e.tc  = lim;
         sb_b.push_back(e);
         if (lim) movf_b = 1'b1;
         mq_b = nq;
      end
      b_step = 1'b1;
      repeat (20) @(negedge clk);
      b_step = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (b_q !== 4'd4 || b_ovf !== 1'b1 || sb_b.size() != 0) begin
         miscompares++;
         $display("FAIL level_mode: got q=%0d ovf=%b pending=%0d, required q=4 ovf=1 pending=0",
                  b_q, b_ovf, sb_b.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a_load_n = 1'b1; a_load_val = '0; a_step = 1'b0; a_up = 1'b1; a_sat = 1'b0; a_clr = 1'b0;
      b_load_n = 1'b1; b_load_val = '0; b_step = 1'b0; b_up = 1'b1; b_sat = 1'b0; b_clr = 1'b0;
      test_reset;
      test_count_presses;
      test_wrap_up;
      test_sat_down;
      test_set_wins;
      test_load_clamp;
      test_reset_mid;
      test_level_mode;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mod_step_counter.md
Name: mod_step_counter

Overview:
- Parametrised successor to the 4-bit T flip-flop load counter: a WIDTH-bit modulo-MODULUS up/down counter with parallel load, per-press stepping from a debounced push-button level, and wrap or saturate mode.
- Sits between the board-key/switch inputs and the binary-to-BCD display path.
- Adds terminal-count and sticky-overflow outputs.

Parameters:
- WIDTH, 8, counter width in bits; 2..16.
- MODULUS, 200, count range 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH.
- EDGE_STEP, 1, 1 = count once per rising edge of step through a 2-flop synchroniser; 0 = count every clk while step is high, with no synchroniser.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_n  in  1  parallel load request, active-low, sampled directly (synchronous input).
- load_val  in  WIDTH  load value.
- step  in  1  count request, active-high (asynchronous when EDGE_STEP=1).
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on the counting edge.
- sat  in  1  mode: 1 = saturate at limits, 0 = wrap modulo MODULUS.
- clr_ovf  in  1  clears the ovf flag.
- q  out  WIDTH  registered count.
- tc  out  1  registered one-cycle terminal-count pulse.
- ovf  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset: on a rising clk edge with rst_n=0:
  - q=0, tc=0, ovf=0.
  - Synchroniser and edge flops = 0.
  - A pending step pulse is discarded. Reset overrides every other input.
- Count pulse, EDGE_STEP=1:
  - s1<=step, s2<=s1, s3<=s2; cnt_en = s2 & ~s3.
  - If step rises before edge k, q changes at edge k+2.
  - Exactly one count per low-to-high transition, regardless of how long step is held.
  - A step held high through reset release counts once.
- Count pulse, EDGE_STEP=0: cnt_en = step, and q changes at the next edge.
- Priority per edge: reset > load > count.
- Load (load_n=0):
  - q <= load_val if load_val < MODULUS, else q <= MODULUS-1 (clamped).
  - A coincident cnt_en is dropped, not deferred.
  - tc=0 on that cycle; ovf is unchanged.
- Count, up=1:
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1: wrap mode q <= 0; sat mode q holds.
- Count, up=0:
  - q > 0: q <= q-1.
  - q == 0: wrap mode q <= MODULUS-1; sat mode q holds.
- Limit event: a count applied while q is at the limit in the counting direction, in either mode.
  - tc=1 for exactly the one cycle following that edge, else 0.
  - ovf is set on the same edge.
- ovf:
  - Cleared by clr_ovf=1 at the next edge.
  - If a limit event and clr_ovf occur on the same edge, set wins (ovf=1).
- Direction or mode change: takes effect on the next counting edge. No state besides q depends on up or sat.
- Arithmetic:
  - Next-state is computed WIDTH+1 bits wide so q+1 never aliases when MODULUS=2^WIDTH.
  - Comparisons use the constant MODULUS-1.
- Out-of-range q: cannot occur in normal operation. If it ever does, the next count or wrap forces q to 0 (up) or MODULUS-1 (down).

Test Plan:
- Reset with WIDTH=8, MODULUS=200, EDGE_STEP=1, then step high for 10 clks, low, repeated 3 times -> q=3; each q change occurs exactly 2 edges after its step rise; tc=0 and ovf=0 throughout.
- load_n=0 with load_val=198, sat=0, up=1, then 2 presses -> q=199, then q=0 with tc=1 for one cycle and ovf=1; clr_ovf=1 for 1 clk -> ovf=0.
- q=0, up=0, sat=1, 1 press -> q stays 0, tc pulses once, ovf=1; then sat=0 and 1 press -> q=199.
- load_val=250 (>= MODULUS) -> q=199 (clamped); load_n=0 on the same edge as cnt_en -> q=load_val and the count is lost.
- EDGE_STEP=0, MODULUS=16, WIDTH=4, step held high for 20 clks from q=0 -> q=4 after wrap, with exactly one tc pulse at the 15->0 transition.
- rst_n=0 for one edge mid-count while ovf=1 and a step pulse is in the synchroniser -> q=0, ovf=0, tc=0; no count occurs after release unless step rises again.
